// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/RESULT/MEM/WB control FSM for the RV32I core.
// Owns pc and instret and drives the shared instruction/data memory port.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        is_alu,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [4:0]  ex_dest,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_next_pc,
  output logic [31:0] pc,
  output logic        exec_en,
  output logic        wb_en,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [31:0] instret,
  output logic        trap
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, RESULT, MEM, WB, TRAP
  } state_t;

  state_t      state, state_next;
  logic [4:0]  flags, cls;
  logic        one_hot;
  logic [31:0] ls_addr, st_data, res, npc;
  logic [4:0]  dest;
  logic        cls_load, cls_store, cls_writes;

  // Class vector layout: {alu, jump, branch, store, load}
  assign flags      = {is_alu, is_jump, is_branch, is_store, is_load};
  assign one_hot    = (flags != '0) && ((flags & (flags - 5'd1)) == '0);
  assign cls_load   = cls[0];
  assign cls_store  = cls[1];
  assign cls_writes = cls[4] | cls[3] | cls[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr   <= '0;
      instret <= '0;
      cls     <= '0;
      ls_addr <= '0;
      st_data <= '0;
      res     <= '0;
      dest    <= '0;
      npc     <= '0;
    end else begin
      state <= state_next;
      case (state)
        FETCH:  if (pc[1:0] == 2'b00 && mem_ready) instr <= mem_rdata;
        DECODE: begin
          cls     <= flags;
          ls_addr <= rs1_val + imm;
          st_data <= rs2_val;
        end
        RESULT: begin
          res  <= ex_result;
          dest <= ex_dest;
          npc  <= ex_next_pc;
        end
        // A load reuses the result register for the fetched word.
        MEM:    if (mem_ready && cls_load) res <= mem_rdata;
        WB: begin
          pc      <= npc;
          instret <= instret + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    exec_en    = 1'b0;
    wb_en      = 1'b0;
    wb_dest    = '0;
    wb_data    = '0;
    trap       = 1'b0;
    case (state)
      FETCH: begin
        if (pc[1:0] != 2'b00) begin
          state_next = TRAP;
        end else begin
          mem_req  = 1'b1;
          mem_addr = pc;
          if (mem_ready) state_next = DECODE;
        end
      end
      DECODE: state_next = one_hot ? EXEC : TRAP;
      EXEC: begin
        exec_en    = 1'b1;
        state_next = RESULT;
      end
      RESULT: begin
        if (cls_load || cls_store)
          state_next = (ls_addr[1:0] != 2'b00) ? TRAP : MEM;
        else
          state_next = WB;
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = cls_store;
        mem_addr  = ls_addr;
        mem_wdata = st_data;
        if (mem_ready) state_next = WB;
      end
      WB: begin
        wb_en      = cls_writes && (dest != '0);
        wb_dest    = dest;
        wb_data    = res;
        state_next = FETCH;
      end
      TRAP: trap = 1'b1;
      default: state_next = TRAP;
    endcase
    // The port must go idle the instant reset asserts, even though the
    // state register already sits in FETCH.
    if (!reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed table-driven bench for core_sequencer plus hand-written trap and
// asynchronous-reset sequences.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instr;
  logic        is_load, is_store, is_branch, is_jump, is_alu;
  logic [31:0] rs1_val, rs2_val, imm, ex_result, ex_next_pc;
  logic [4:0]  ex_dest;
  logic [31:0] pc, wb_data, instret;
  logic        exec_en, wb_en, trap;
  logic [4:0]  wb_dest;

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instr(instr),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .is_alu(is_alu),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .ex_dest(ex_dest), .ex_result(ex_result), .ex_next_pc(ex_next_pc),
    .pc(pc), .exec_en(exec_en), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .instret(instret), .trap(trap)
  );

  localparam logic [4:0] F_ALU = 5'b10000, F_JMP = 5'b01000, F_BR = 5'b00100,
                         F_ST = 5'b00010, F_LD = 5'b00001;

  typedef struct {
    logic [4:0]  flags;
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  dest;
    logic [31:0] result, next_pc, rdata, fetch_word;
    int unsigned waits;
    int unsigned exp_cycles;
    logic        exp_mem, exp_we;
    logic [31:0] exp_addr;
    logic        exp_wb;
    logic [31:0] exp_wb_data;
  } vec_t;

  vec_t        tbl[8];
  vec_t        v;
  int          passed = 0, total = 0;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_inputs(input vec_t x);
    {is_alu, is_jump, is_branch, is_store, is_load} = x.flags;
    rs1_val = x.rs1; rs2_val = x.rs2; imm = x.imm;
    ex_dest = x.dest; ex_result = x.result; ex_next_pc = x.next_pc;
  endtask

  // Entered at a falling edge with the DUT in FETCH; returns at the falling
  // edge of the next FETCH cycle.
  task automatic run_instr(input vec_t x, input string tag);
    logic [31:0] start_ir, f_addr, d_addr, d_wd, wb_v;
    logic        d_we, done;
    logic [4:0]  wb_d;
    int cyc, n_exec, exec_at, wb_cnt, data_reqs, unstable, fetches, waited;
    start_ir = instret; done = 1'b0;
    cyc = 0; n_exec = 0; exec_at = 0; wb_cnt = 0; data_reqs = 0; unstable = 0;
    fetches = 0; waited = 0;
    f_addr = '0; d_addr = '0; d_wd = '0; d_we = 1'b0; wb_v = '0; wb_d = '0;
    set_inputs(x);
    for (int k = 0; k < 40 && !done; k++) begin
      cyc++;
      if (instret !== start_ir) begin
        done = 1'b1;
      end else begin
        mem_ready = 1'b0;
        if (exec_en) begin n_exec++; exec_at = cyc; end
        if (wb_en) begin wb_cnt++; wb_d = wb_dest; wb_v = wb_data; end
        if (mem_req) begin
          if (n_exec == 0) begin
            fetches++; f_addr = mem_addr; mem_rdata = x.fetch_word; mem_ready = 1'b1;
          end else begin
            if (data_reqs == 0) begin
              d_addr = mem_addr; d_we = mem_we; d_wd = mem_wdata;
            end else if (mem_addr !== d_addr || mem_we !== d_we || mem_wdata !== d_wd) begin
              unstable++;
            end
            data_reqs++;
            if (waited < int'(x.waits)) begin
              waited++; mem_rdata = 32'hBAD0_BAD0;
            end else begin
              mem_ready = 1'b1; mem_rdata = x.rdata;
            end
          end
        end
        @(negedge clk);
      end
    end
    chk({tag, "_completed"}, {31'd0, done}, 32'd1);
    chk({tag, "_cycles"}, cyc - 1, x.exp_cycles);
    chk({tag, "_exec_pulses"}, n_exec, 1);
    chk({tag, "_exec_cycle"}, exec_at, 3);
    chk({tag, "_fetches"}, fetches, 1);
    chk({tag, "_fetch_addr"}, f_addr, m_pc);
    chk({tag, "_instr"}, instr, x.fetch_word);
    chk({tag, "_data_reqs"}, data_reqs, x.exp_mem ? x.waits + 1 : 0);
    if (x.exp_mem) begin
      chk({tag, "_mem_addr"}, d_addr, x.exp_addr);
      chk({tag, "_mem_we"}, {31'd0, d_we}, {31'd0, x.exp_we});
      chk({tag, "_mem_stable"}, unstable, 0);
      if (x.exp_we) chk({tag, "_mem_wdata"}, d_wd, x.rs2);
    end
    chk({tag, "_wb_count"}, wb_cnt, x.exp_wb ? 1 : 0);
    if (x.exp_wb) begin
      chk({tag, "_wb_dest"}, {27'd0, wb_d}, {27'd0, x.dest});
      chk({tag, "_wb_data"}, wb_v, x.exp_wb_data);
    end
    chk({tag, "_pc"}, pc, x.next_pc);
    chk({tag, "_instret"}, instret, start_ir + 32'd1);
    m_pc = x.next_pc;
  endtask

  task automatic run_trap(input vec_t x, input int ncyc, input int exp_reqs,
                          input int exp_execs, input string tag);
    logic [31:0] start_ir;
    int reqs, execs;
    start_ir = instret; reqs = 0; execs = 0;
    set_inputs(x);
    for (int k = 0; k < ncyc; k++) begin
      mem_ready = 1'b0;
      if (exec_en) execs++;
      if (mem_req) begin
        reqs++; mem_ready = 1'b1;
        mem_rdata = (execs == 0) ? x.fetch_word : x.rdata;
      end
      @(negedge clk);
    end
    chk({tag, "_trap"}, {31'd0, trap}, 32'd1);
    chk({tag, "_reqs"}, reqs, exp_reqs);
    chk({tag, "_execs"}, execs, exp_execs);
    chk({tag, "_mem_req_idle"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_instret_held"}, instret, start_ir);
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    m_pc = 32'h100;
  endtask

  initial begin
    tbl[0] = '{flags:F_ALU, rs1:0, rs2:0, imm:0, dest:5, result:32'h2A, next_pc:32'h104,
               rdata:0, fetch_word:32'h0050_0293, waits:0, exp_cycles:5, exp_mem:0,
               exp_we:0, exp_addr:0, exp_wb:1, exp_wb_data:32'h2A};
    tbl[1] = '{flags:F_LD, rs1:32'h1000, rs2:32'h77, imm:8, dest:7, result:32'h1234,
               next_pc:32'h108, rdata:32'hDEAD_BEEF, fetch_word:32'h0080_A383, waits:3,
               exp_cycles:9, exp_mem:1, exp_we:0, exp_addr:32'h1008, exp_wb:1,
               exp_wb_data:32'hDEAD_BEEF};
    tbl[2] = '{flags:F_ST, rs1:32'h1FF0, rs2:32'h55, imm:32'h10, dest:3, result:32'h4444,
               next_pc:32'h10C, rdata:0, fetch_word:32'h0020_A823, waits:0, exp_cycles:6,
               exp_mem:1, exp_we:1, exp_addr:32'h2000, exp_wb:0, exp_wb_data:0};
    tbl[3] = '{flags:F_BR, rs1:0, rs2:0, imm:0, dest:4, result:1, next_pc:32'h80,
               rdata:0, fetch_word:32'hFE00_0AE3, waits:0, exp_cycles:5, exp_mem:0,
               exp_we:0, exp_addr:0, exp_wb:0, exp_wb_data:0};
    tbl[4] = '{flags:F_JMP, rs1:0, rs2:0, imm:0, dest:1, result:32'h84, next_pc:32'h200,
               rdata:0, fetch_word:32'h1800_00EF, waits:0, exp_cycles:5, exp_mem:0,
               exp_we:0, exp_addr:0, exp_wb:1, exp_wb_data:32'h84};
    tbl[5] = '{flags:F_ALU, rs1:0, rs2:0, imm:0, dest:0, result:32'hFFFF, next_pc:32'h204,
               rdata:0, fetch_word:32'h0000_0013, waits:0, exp_cycles:5, exp_mem:0,
               exp_we:0, exp_addr:0, exp_wb:0, exp_wb_data:0};
    tbl[6] = '{flags:F_LD, rs1:32'h300, rs2:0, imm:32'hFFFF_FFFC, dest:0, result:32'h9,
               next_pc:32'h208, rdata:32'hCAFE_F00D, fetch_word:32'hFFC0_2003, waits:1,
               exp_cycles:7, exp_mem:1, exp_we:0, exp_addr:32'h2FC, exp_wb:0, exp_wb_data:0};
    tbl[7] = '{flags:F_ST, rs1:0, rs2:32'hA5A5_A5A5, imm:32'h40, dest:9, result:32'h1,
               next_pc:32'h20C, rdata:0, fetch_word:32'h0400_2023, waits:2, exp_cycles:8,
               exp_mem:1, exp_we:1, exp_addr:32'h40, exp_wb:0, exp_wb_data:0};

    reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    v = tbl[5]; v.flags = 5'b00000; set_inputs(v);
    m_pc = 32'h100;

    // Reset values while held, then first cycle after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we_wdata", {mem_wdata[30:0], mem_we}, 32'd0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_instret", instret, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_strobes", {28'd0, exec_en, wb_en, trap, 1'b0}, 32'd0);
    chk("rst_wb_bus", wb_data | {27'd0, wb_dest}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("c1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("c1_mem_addr", mem_addr, 32'h100);
    chk("c1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("c1_strobes", {29'd0, exec_en, wb_en, trap}, 32'd0);

    for (int i = 0; i < 8; i++) run_instr(tbl[i], $sformatf("v%0d", i));

    // Jump to a misaligned target: the following fetch traps without a request
    v = tbl[4]; v.next_pc = 32'h6; v.exp_wb_data = 32'h84;
    run_instr(v, "jmp_mis");
    run_trap(tbl[0], 6, 0, 0, "fetch_mis");
    chk("fetch_mis_pc", pc, 32'h6);

    // Misaligned load address traps after RESULT with no data request
    do_reset();
    v = tbl[1]; v.rs1 = 32'h1000; v.imm = 32'h2;
    run_trap(v, 10, 1, 1, "ls_mis");

    do_reset();
    v = tbl[0]; v.flags = 5'b00000;
    run_trap(v, 6, 1, 0, "no_flags");

    do_reset();
    v = tbl[0]; v.flags = F_ALU | F_LD;
    run_trap(v, 6, 1, 0, "two_flags");

    // Asynchronous reset in the middle of a stalled fetch
    do_reset();
    run_instr(tbl[0], "pre_async");
    mem_ready = 1'b0;
    @(negedge clk);
    chk("stall_mem_req", {31'd0, mem_req}, 32'd1);
    chk("stall_mem_addr", mem_addr, 32'h104);
    #2 reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_pc", pc, 32'h100);
    chk("async_instret", instret, 32'd0);
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_mem_addr", mem_addr, 32'h100);
    chk("post_rst_exec", {31'd0, exec_en}, 32'd0);
    chk("post_rst_instr", instr, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the single-issue RV32I core. Each instruction passes in strict order through fetch, decode, the registered execute stage, an optional memory access, and register write-back. The block owns the program counter and the retired-instruction counter. It also drives the core's single shared memory port, which carries both instruction fetches and load/store data (word accesses only).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store, 0 = read
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  store data
- mem_ready  in  1  memory accepts (write) or returns data (read) this cycle
- mem_rdata  in  32  read data, valid when mem_req & mem_ready & !mem_we
- instr  out  32  latched instruction word for the decoder
- is_load, is_store, is_branch, is_jump, is_alu  in  1 each  decoder class flags for instr
- rs1_val, rs2_val, imm  in  32 each  decoded operands for load/store addressing and store data
- ex_dest  in  5  destination register from execute stage
- ex_result  in  32  execute-stage result
- ex_next_pc  in  32  execute-stage next PC
- pc  out  32  current PC, drives the execute stage curr_pc
- exec_en  out  1  one-cycle execute-stage enable
- wb_en  out  1  register-file write strobe
- wb_dest  out  5  write-back register
- wb_data  out  32  write-back data
- instret  out  32  retired-instruction counter
- trap  out  1  sticky fault flag

## Operation
- States: FETCH, DECODE, EXEC, RESULT, MEM, WB, TRAP.
- **FETCH**
  - Drives mem_req=1, mem_we=0, mem_addr=pc.
  - If pc[1:0]≠0, goes to TRAP without requesting memory.
  - On mem_ready, latches instr=mem_rdata and goes to DECODE.
- **DECODE**
  - Flags are sampled this cycle.
  - If no flag is set, or more than one flag is set, goes to TRAP.
  - Otherwise latches the class and ls_addr = rs1_val + imm (mod 2^32), then goes to EXEC.
- **EXEC**
  - Asserts exec_en=1 for exactly this cycle, then goes to RESULT.
- **RESULT**
  - ex_result, ex_dest and ex_next_pc are valid here; the sequencer latches them.
  - Load or store: goes to MEM; if ls_addr[1:0]≠0, goes to TRAP instead.
  - Otherwise goes to WB.
- **MEM**
  - Drives mem_req=1, mem_addr=ls_addr, mem_we=store, mem_wdata=rs2_val (latched in DECODE).
  - On mem_ready goes to WB; a load latches mem_rdata as the write-back value.
- **WB**
  - Asserts wb_en=1 for one cycle for alu, jump and load, only when dest≠0.
  - wb_data is ex_result for alu/jump and the loaded word for load.
  - Branch and store never write.
  - Updates pc←latched ex_next_pc for every class, increments instret (wraps 0xFFFF_FFFF→0), then goes to FETCH.
- **TRAP**
  - Sets trap=1 and holds; mem_req=0, exec_en=0, wb_en=0.
  - Only reset leaves TRAP.
- mem_ready is ignored whenever mem_req=0.

## Timing
- Reset values:
  - pc=RESET_PC; state=FETCH; instr=0, instret=0.
  - mem_req, mem_we, exec_en, wb_en, trap all 0.
  - mem_addr, mem_wdata, wb_dest, wb_data all 0.
- First mem_req=1 in the first cycle after reset deasserts.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ready=0.
  - A transfer completes on the edge where both are high.
  - mem_req drops the next cycle; no back-to-back requests.
  - Each wait cycle adds exactly one cycle of latency.
- Latency with zero-wait memory (mem_ready=1 when requested):
  - non-memory instruction: 5 cycles (FETCH, DECODE, EXEC, RESULT, WB);
  - load or store: 6 cycles.
- instret and pc update on the edge leaving WB.
- Reset asserted mid-transfer:
  - mem_req drops asynchronously and the pending transfer is abandoned.
  - A late mem_ready is ignored.
  - The counter and PC return to reset values.

## Test plan
- **Reset:** RESET_PC=0x100, release reset -> cycle 1 mem_req=1, mem_addr=0x100, mem_we=0; all other outputs at reset values.
- **ALU instruction:** zero-wait memory, flags is_alu, ex_dest=5, ex_result=0x2A, ex_next_pc=0x104 -> exec_en pulses in cycle 3; wb_en=1 with wb_dest=5, wb_data=0x2A in cycle 5; pc=0x104 and instret=1 afterward.
- **Load with waits:** rs1_val=0x1000, imm=8, mem_ready delayed 3 cycles, mem_rdata=0xDEADBEEF, ex_dest=7 -> mem_addr=0x1008, mem_we=0 held stable through the wait; wb_data=0xDEADBEEF to x7; total 9 cycles.
- **Store and branch:** store of rs2_val=0x55 to 0x2000 -> mem_we=1, mem_wdata=0x55, no wb_en. Branch with ex_next_pc=0x80 -> pc=0x80, no wb_en.
- **Traps:**
  - ls_addr=0x1002 -> TRAP with trap=1 and no mem_req;
  - zero flags in DECODE -> TRAP;
  - jump with ex_next_pc=0x6 -> next FETCH traps.
- **Async reset:** reset asserted while mem_req=1, mem_ready=0 -> mem_req=0 in the same cycle, pc=RESET_PC; a stale mem_ready after release does not advance the FSM.
